// File: rtl/ahb_cmd_arb_pkg.sv
// Shared types and constants for the AHB5 command arbiter.
// Build option: AHB_CMD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package ahb_cmd_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic              burst;
    logic              sec;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_cmd_arb_pick.sv
// Combinational winner selection: round-robin from ptr, or lowest index wins
// when AHB_CMD_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module ahb_arb_pick
  import ahb_cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld
);

  logic found;

  assign gnt_vld = |req_valid;

`ifdef AHB_CMD_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  // Walk NUM_REQ slots starting at ptr; the index wraps back below NUM_REQ.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!found && req_valid[jj]) begin
        gnt[jj] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_cmd_arbiter.sv
// Arbitrates NUM_REQ level requesters onto one AHB5 master command port.
// Build option: AHB_CMD_ARB_FIXED_PRIO_EN (fixed priority, no ptr register).
module ahb_cmd_arbiter
  import ahb_cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_burst,
  input  logic [NUM_REQ-1:0]        req_sec,
  input  logic [NUM_REQ*DATA_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic                      busy,
  output logic                      cmd_start,
  output logic                      cmd_write,
  output logic                      cmd_burst,
  output logic                      cmd_sec,
  output logic [DATA_W-1:0]         cmd_addr,
  output logic [DATA_W-1:0]         cmd_wdata,
  input  logic                      cmd_done,
  input  logic                      cmd_error,
  input  logic [DATA_W-1:0]         cmd_rdata
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  ptr;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_vld;

`ifdef AHB_CMD_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Next search starts just past the requester being answered this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) begin
      ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  ahb_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    win_d   = win_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              cmd_d.write = req_write[i];
              cmd_d.burst = req_burst[i];
              cmd_d.sec   = req_sec[i];
              cmd_d.addr  = req_addr[i*DATA_W +: DATA_W];
              cmd_d.wdata = req_wdata[i*DATA_W +: DATA_W];
              win_d       = IDX_W'(i);
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cmd_done) begin
          rdata_d = cmd_q.write ? '0 : cmd_rdata;
          err_d   = cmd_error;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      win_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      win_q   <= win_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_done[i] = (state_q == RESP) && (win_q == IDX_W'(i));
    end
  end

  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign rsp_error = (state_q == RESP) && err_q;
  assign busy      = (state_q != IDLE);
  assign cmd_start = (state_q == ISSUE);
  assign cmd_write = cmd_q.write;
  assign cmd_burst = cmd_q.burst;
  assign cmd_sec   = cmd_q.sec;
  assign cmd_addr  = cmd_q.addr;
  assign cmd_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// Scoreboard bench for ahb_cmd_arbiter: directed cases plus random traffic,
// checked against a queue-based arbitration model and a responding master model.
module tb_ahb_cmd_arbiter;

  localparam int N = 4;

  logic            hclk, hreset;
  logic [N-1:0]    req_valid, req_write, req_burst, req_sec;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N-1:0]    req_done;
  logic [31:0]     rsp_rdata;
  logic            rsp_error, busy;
  logic            cmd_start, cmd_write, cmd_burst, cmd_sec;
  logic [31:0]     cmd_addr, cmd_wdata;
  logic            cmd_done, cmd_error;
  logic [31:0]     cmd_rdata;

  ahb_cmd_arbiter #(.NUM_REQ(N)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_write(req_write), .req_burst(req_burst), .req_sec(req_sec),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_sec(cmd_sec),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_rdata(cmd_rdata)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   done_log[$];
  int   total = 0, bad = 0, cyc = 0;

  // master controls (main writes, master reads)
  int          force_delay = -1, force_err = -1;
  bit          force_rd_en = 0;
  logic [31:0] force_rd = '0;
  bit          hold_done = 0, spur_req = 0;

  // monitor state (monitor writes, master reads cur_*)
  int          ref_ptr = 0, cur_idx = 0;
  bit          cur_write = 0, stab = 0;
  logic [N-1:0] prev_valid = '0;
  logic [31:0] e_addr, e_wdata;
  logic        e_write, e_burst, e_sec;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  always @(posedge hclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
  endtask

  function automatic int ref_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Monitor: arbitration model, command stability, response scoreboard.
  initial begin
    exp_t e;
    int   win;
    forever begin
      @(negedge hclk);
      if (hreset) begin
        ref_ptr    = 0;
        stab       = 0;
        prev_valid = '0;
      end else begin
        if (req_done != '0) begin
          if (sb.size() == 0) begin
            fail("unexpected_done", $sformatf("got req_done=%b, expected none", req_done));
          end else begin
            e = sb.pop_front();
            chk("done_onehot", 32'(req_done), 32'(1) << e.idx);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
            chk("done_cycle", cyc, e.cyc);
`ifndef AHB_CMD_ARB_FIXED_PRIO_EN
            ref_ptr = (e.idx + 1) % N;
`endif
          end
          for (int i = 0; i < N; i++) if (req_done[i]) done_log.push_back(i);
        end
        if (cmd_start) begin
          if (stab) fail("start_overlap", "got cmd_start while a command is outstanding, expected 0");
          win = ref_pick(prev_valid, ref_ptr);
          if (win < 0) begin
            fail("spurious_start", $sformatf("got cmd_start with prior req_valid=%b, expected none", prev_valid));
          end else begin
            e_write   = req_write[win];
            e_burst   = req_burst[win];
            e_sec     = req_sec[win];
            e_addr    = req_addr[win*32 +: 32];
            e_wdata   = req_wdata[win*32 +: 32];
            cur_idx   = win;
            cur_write = e_write;
            stab      = 1;
            chk("start_write", 32'(cmd_write), 32'(e_write));
            chk("start_burst", 32'(cmd_burst), 32'(e_burst));
            chk("start_sec", 32'(cmd_sec), 32'(e_sec));
            chk("start_addr", cmd_addr, e_addr);
            chk("start_wdata", cmd_wdata, e_wdata);
          end
        end else if (stab) begin
          chk("hold_write", 32'(cmd_write), 32'(e_write));
          chk("hold_burst", 32'(cmd_burst), 32'(e_burst));
          chk("hold_sec", 32'(cmd_sec), 32'(e_sec));
          chk("hold_addr", cmd_addr, e_addr);
          chk("hold_wdata", cmd_wdata, e_wdata);
          if (cmd_done) stab = 0;
        end
        prev_valid = req_valid;
      end
    end
  end

  // Master model: answers each cmd_start after a delay, pushes the expected response.
  initial begin
    int          cnt;
    logic        st, hr, er;
    logic [31:0] rd;
    cnt = -1;
    cmd_done = 1'b0; cmd_error = 1'b0; cmd_rdata = '0;
    forever begin
      @(negedge hclk);
      st = cmd_start;
      hr = hreset;
      @(posedge hclk); #1;
      cmd_done  = 1'b0;
      cmd_error = 1'($urandom_range(0, 1));
      cmd_rdata = $urandom;
      if (hr) cnt = -1;
      else if (st && !hold_done) cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
      if (cnt == 0) begin
        rd = force_rd_en ? force_rd : $urandom;
        er = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 3) == 0);
        cmd_done  = 1'b1;
        cmd_rdata = rd;
        cmd_error = er;
        sb.push_back('{idx: cur_idx, rdata: (cur_write ? 32'h0 : rd), err: er, cyc: cyc + 1});
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (spur_req) cmd_done = 1'b1;
    end
  end

  task automatic set_fields(input int i, input bit w, input bit b, input bit s,
                            input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_burst[i] = b;
    req_sec[i]   = s;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Raise one request in an idle cycle t; cmd_start must appear at t+1 only.
  task automatic issue(input int i, input bit w, input bit b, input bit s,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge hclk); #1;
    set_fields(i, w, b, s, a, d);
    req_valid[i] = 1'b1;
    @(negedge hclk); chk("start_t0", 32'(cmd_start), 32'h0);
    @(negedge hclk); chk("start_t1", 32'(cmd_start), 32'h1);
  endtask

  // Run until n more completions; drop each finished requester (or all at the end if hold).
  task automatic run_until(input int n, input bit hold);
    int start, k;
    logic [N-1:0] dm;
    start = done_log.size();
    k = 0;
    while (done_log.size() - start < n && k < 300) begin
      @(negedge hclk); dm = req_done; k++;
      @(posedge hclk); #1;
      if (!hold) req_valid = req_valid & ~dm;
    end
    if (hold) req_valid = '0;
    if (done_log.size() - start < n)
      fail("done_timeout", $sformatf("got %0d completions, expected %0d", done_log.size() - start, n));
    @(negedge hclk); chk("idle_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    int exp_order[$];
    int k;
    logic [N-1:0] dm;
    hreset = 1'b1;
    req_valid = '0; req_write = '0; req_burst = '0; req_sec = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(cmd_start), 32'h0);
    chk("rst_done", 32'(req_done), 32'h0);
    chk("rst_addr", cmd_addr, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // all four held: arbitration order
    @(posedge hclk); #1;
    for (int i = 0; i < N; i++) set_fields(i, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i) * 4, 32'h0);
    req_valid = '1;
    done_log.delete();
`ifdef AHB_CMD_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    run_until(exp_order.size(), 1'b1);
    for (int i = 0; i < exp_order.size(); i++)
      if (i < done_log.size()) chk($sformatf("order%0d", i), done_log[i], exp_order[i]);

    // read from requester 0, done 3 cycles after start
    force_delay = 2; force_rd_en = 1; force_rd = 32'hA5A5_0001; force_err = 0;
    issue(0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    run_until(1, 1'b0);
    chk("rd0_idx", done_log[$], 0);

    // write from requester 2 with error
    force_delay = 1; force_rd = 32'hFFFF_FFFF; force_err = 1;
    issue(2, 1'b1, 1'b0, 1'b0, 32'h300, 32'h55);
    run_until(1, 1'b0);
    chk("wr2_idx", done_log[$], 2);
    force_rd_en = 0; force_err = -1;

    // cmd_done while idle is ignored
    @(negedge hclk); spur_req = 1;
    @(posedge hclk); #2; spur_req = 0;
    repeat (3) begin
      @(negedge hclk);
      chk("spur_busy", 32'(busy), 32'h0);
    end

    // burst write from requester 1; request withdrawn after capture
    force_delay = 4;
    issue(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h10);
    chk("burst_flag", 32'(cmd_burst), 32'h1);
    @(posedge hclk); #1;
    req_valid[1] = 1'b0;
    req_addr[32 +: 32] = 32'hDEAD_0000;
    req_sec[1] = 1'b0;
    run_until(1, 1'b0);
    chk("burst_idx", done_log[$], 1);
    force_delay = -1;

    // reset during WAIT
    hold_done = 1;
    issue(2, 1'b0, 1'b0, 1'b1, 32'h400, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    req_valid = '0;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_start", 32'(cmd_start), 32'h0);
    chk("rstw_addr", cmd_addr, 32'h0);
    repeat (4) @(negedge hclk);
    hold_done = 0;
    @(posedge hclk); #1;
    set_fields(1, 1'b0, 1'b0, 1'b0, 32'h510, 32'h0);
    set_fields(2, 1'b0, 1'b0, 1'b0, 32'h520, 32'h0);
    req_valid = 4'b0110;
    run_until(1, 1'b0);
    chk("post_rst_idx", done_log[$], 1);
    run_until(1, 1'b0);

    // requester 3 arrives during requester 0's response cycle
    issue(0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
    k = 0;
    while (req_done[0] !== 1'b1 && k < 40) begin
      @(negedge hclk); k++;
    end
    if (k >= 40) fail("resp_timeout", "got no req_done[0], expected one");
    #1;
    set_fields(3, 1'b1, 1'b0, 1'b0, 32'h700, 32'h77);
    req_valid[3] = 1'b1;
    @(posedge hclk); #1;
    req_valid[0] = 1'b0;
    @(negedge hclk); chk("late_t1", 32'(cmd_start), 32'h0);
    @(negedge hclk); chk("late_t2", 32'(cmd_start), 32'h1);
    run_until(1, 1'b0);
    chk("late_idx", done_log[$], 3);

    // random traffic, then drain
    for (int c = 0; c < 700; c++) begin
      @(negedge hclk); dm = req_done;
      @(posedge hclk); #1;
      for (int i = 0; i < N; i++) begin
        if (dm[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && c < 550 && $urandom_range(0, 3) == 0) begin
          set_fields(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, $urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    @(negedge hclk);
    chk("drain_valid", 32'(req_valid), 32'h0);
    chk("drain_busy", 32'(busy), 32'h0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
